// File: rtl/brq_inst_mem.sv
// brq_inst_mem: dual halfword-bank instruction memory with boot loader FSM.
// Define IMEM_LOAD_CHECKSUM_EN to build the per-session load checksum.
module brq_inst_mem #(
  parameter int HalfWord  = 16,
  parameter int DataWidth = 32,
  parameter int AddrWidth = 16,
  parameter int MemWords  = 4096
) (
  input  logic                         brq_clk,
  input  logic                         brq_rst_n,
  input  logic [AddrWidth-1:0]         inst_mem_address,
  output logic [HalfWord-1:0]          inst_mem_lsb,
  output logic [HalfWord-1:0]          inst_mem_msb,
  input  logic                         ld_start,
  input  logic                         ld_valid,
  input  logic [DataWidth-1:0]         ld_data,
  input  logic                         ld_last,
  output logic                         ld_ready,
  output logic                         imem_busy,
  output logic [$clog2(MemWords):0]    ld_count,
  output logic [DataWidth-1:0]         ld_checksum
);

  localparam int IdxW = $clog2(MemWords);
  localparam int CntW = IdxW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DONE
  } state_e;

  state_e state_q;

  logic [HalfWord-1:0] even_q [MemWords];
  logic [HalfWord-1:0] odd_q  [MemWords];

  logic            accept;
  logic            last_slot;
  logic [IdxW-1:0] widx;
  logic [IdxW-1:0] k;
  logic [IdxW-1:0] kn;
  logic            unused_addr;

  assign accept    = ld_ready & ld_valid;
  assign last_slot = (ld_count == CntW'(MemWords - 1));
  assign widx      = ld_count[IdxW-1:0];

  always_ff @(posedge brq_clk or negedge brq_rst_n) begin
    if (!brq_rst_n) begin
      state_q     <= S_IDLE;
      ld_ready    <= 1'b0;
      imem_busy   <= 1'b0;
      ld_count    <= '0;
`ifdef IMEM_LOAD_CHECKSUM_EN
      ld_checksum <= '0;
`endif
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (ld_start) begin
            state_q     <= S_LOAD;
            ld_ready    <= 1'b1;
            imem_busy   <= 1'b1;
            ld_count    <= '0;
`ifdef IMEM_LOAD_CHECKSUM_EN
            ld_checksum <= '0;
`endif
          end
        end
        S_LOAD: begin
          if (accept) begin
            ld_count    <= ld_count + 1'b1;
`ifdef IMEM_LOAD_CHECKSUM_EN
            ld_checksum <= ld_checksum + ld_data;
`endif
            // bank full stops the session: no wrap onto word 0
            if (ld_last || last_slot) begin
              state_q  <= S_DONE;
              ld_ready <= 1'b0;
            end
          end
        end
        S_DONE: begin
          state_q   <= S_IDLE;
          imem_busy <= 1'b0;
        end
        default: begin
          state_q   <= S_IDLE;
          ld_ready  <= 1'b0;
          imem_busy <= 1'b0;
        end
      endcase
    end
  end

`ifndef IMEM_LOAD_CHECKSUM_EN
  assign ld_checksum = '0;
`endif

  always_ff @(posedge brq_clk) begin
    if (accept) begin
      even_q[widx] <= ld_data[HalfWord-1:0];
      odd_q[widx]  <= ld_data[DataWidth-1:HalfWord];
    end
  end

  assign k  = inst_mem_address[IdxW:1];
  assign kn = k + 1'b1;
  assign unused_addr = ^inst_mem_address[AddrWidth-1:IdxW+1];

  always_comb begin
    inst_mem_lsb = even_q[k];
    inst_mem_msb = odd_q[k];
    if (imem_busy) begin
      inst_mem_lsb = HalfWord'(16'h0013);
      inst_mem_msb = '0;
    end else if (inst_mem_address[0]) begin
      inst_mem_lsb = odd_q[k];
      inst_mem_msb = even_q[kn];
    end
  end

endmodule

// File: tb/tb_brq_inst_mem.sv
// tb_brq_inst_mem: randomized loader/fetch bench for brq_inst_mem.
// Reference model is a flat halfword image of the loaded program.
module tb_brq_inst_mem;

  localparam int MW = 4;
  localparam int NH = 2 * MW;
`ifdef IMEM_LOAD_CHECKSUM_EN
  localparam bit CksEn = 1'b1;
`else
  localparam bit CksEn = 1'b0;
`endif

  logic        brq_clk;
  logic        brq_rst_n;
  logic [15:0] inst_mem_address;
  logic [15:0] inst_mem_lsb;
  logic [15:0] inst_mem_msb;
  logic        ld_start;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        ld_last;
  logic        ld_ready;
  logic        imem_busy;
  logic [2:0]  ld_count;
  logic [31:0] ld_checksum;

  brq_inst_mem #(
    .HalfWord (16),
    .DataWidth(32),
    .AddrWidth(16),
    .MemWords (MW)
  ) dut (
    .brq_clk         (brq_clk),
    .brq_rst_n       (brq_rst_n),
    .inst_mem_address(inst_mem_address),
    .inst_mem_lsb    (inst_mem_lsb),
    .inst_mem_msb    (inst_mem_msb),
    .ld_start        (ld_start),
    .ld_valid        (ld_valid),
    .ld_data         (ld_data),
    .ld_last         (ld_last),
    .ld_ready        (ld_ready),
    .imem_busy       (imem_busy),
    .ld_count        (ld_count),
    .ld_checksum     (ld_checksum)
  );

  initial brq_clk = 1'b0;
  always #5 brq_clk = ~brq_clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] hw [NH];
  bit          known [NH];
  logic [31:0] sw [MW];
  int          widx;
  logic [31:0] sum;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge brq_clk);
    #1;
  endtask

  task automatic model_write(input int idx, input logic [31:0] d);
    hw[2*idx]      = d[15:0];
    hw[2*idx+1]    = d[31:16];
    known[2*idx]   = 1'b1;
    known[2*idx+1] = 1'b1;
  endtask

  task automatic check_fetch(input logic [15:0] h);
    int a;
    int b;
    inst_mem_address = h;
    #1;
    a = int'(h) % NH;
    b = (a + 1) % NH;
    if (known[a]) check($sformatf("lsb h=%0d", h), 32'(inst_mem_lsb), 32'(hw[a]));
    if (known[b]) check($sformatf("msb h=%0d", h), 32'(inst_mem_msb), 32'(hw[b]));
  endtask

  task automatic check_nop(input string tag);
    inst_mem_address = 16'h0;
    #1;
    check({tag, "_lsb"}, 32'(inst_mem_lsb), 32'h0013);
    check({tag, "_msb"}, 32'(inst_mem_msb), 32'h0000);
  endtask

  task automatic push(input logic [31:0] d, input bit last);
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = last;
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    model_write(widx, d);
    widx++;
    sum += d;
  endtask

  task automatic start_session();
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    widx = 0;
    sum  = 32'h0;
    check("busy_load", 32'(imem_busy), 32'd1);
    check("ready_load", 32'(ld_ready), 32'd1);
    check("count_clr", 32'(ld_count), 32'd0);
    check_nop("nop_load");
  endtask

  task automatic session(input int n, input bit use_last, input int gap,
                         input bit rnd_gap);
    start_session();
    for (int i = 0; i < n; i++) begin
      int g;
      g = rnd_gap ? int'($urandom_range(0, gap)) : gap;
      for (int j = 0; j < g; j++) begin
        ld_valid = 1'b0;
        ld_data  = $urandom;
        ld_start = rnd_gap ? 1'($urandom_range(0, 1)) : 1'b0;
        tick();
        check("count_gap", 32'(ld_count), 32'(i));
      end
      ld_start = 1'b0;
      push(sw[i], use_last && (i == n - 1));
      check("count_acc", 32'(ld_count), 32'(i + 1));
    end
    check("busy_done", 32'(imem_busy), 32'd1);
    check("ready_done", 32'(ld_ready), 32'd0);
    check_nop("nop_done");
    tick();
    check("busy_idle", 32'(imem_busy), 32'd0);
    check("ready_idle", 32'(ld_ready), 32'd0);
    check("count_end", 32'(ld_count), 32'(n));
    check("checksum", ld_checksum, CksEn ? sum : 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NH; i++) known[i] = 1'b0;
    brq_rst_n        = 1'b0;
    inst_mem_address = 16'h0;
    ld_start         = 1'b0;
    ld_valid         = 1'b0;
    ld_data          = 32'h0;
    ld_last          = 1'b0;
    widx             = 0;
    sum              = 32'h0;
    #1;
    check("rst_busy", 32'(imem_busy), 32'd0);
    check("rst_ready", 32'(ld_ready), 32'd0);
    check("rst_count", 32'(ld_count), 32'd0);
    check("rst_cks", ld_checksum, 32'h0);
    repeat (2) tick();
    brq_rst_n = 1'b1;
    tick();

    sw[0] = 32'hAAAA1111;
    sw[1] = 32'hBBBB2222;
    session(2, 1'b1, 0, 1'b0);
    check_fetch(16'd0);
    check_fetch(16'd1);
    check_fetch(16'd2);
    check("h2_msb_lit", 32'(inst_mem_msb), 32'h0000BBBB);

    ld_valid = 1'b1;
    ld_data  = 32'hDEADBEEF;
    repeat (3) begin
      tick();
      check("idle_ready", 32'(ld_ready), 32'd0);
      check("idle_count", 32'(ld_count), 32'd2);
    end
    ld_valid = 1'b0;
    check_fetch(16'd0);
    check_fetch(16'd1);

    for (int i = 0; i < 3; i++) sw[i] = $urandom;
    session(3, 1'b1, 4, 1'b0);
    for (int h = 0; h < 6; h++) check_fetch(16'(h));

    start_session();
    for (int i = 0; i < 3; i++) push($urandom, 1'b0);
    check("mid_busy", 32'(imem_busy), 32'd1);
    brq_rst_n = 1'b0;
    #1;
    check("mrst_busy", 32'(imem_busy), 32'd0);
    check("mrst_ready", 32'(ld_ready), 32'd0);
    check("mrst_count", 32'(ld_count), 32'd0);
    check("mrst_cks", ld_checksum, 32'h0);
    tick();
    brq_rst_n = 1'b1;
    tick();
    for (int h = 0; h < 6; h++) check_fetch(16'(h));
    sw[0] = 32'h12345678;
    sw[1] = 32'h9ABCDEF0;
    session(2, 1'b1, 1, 1'b0);
    check_fetch(16'd0);

    for (int i = 0; i < MW; i++) sw[i] = $urandom;
    session(MW, 1'b0, 0, 1'b0);
    check_fetch(16'd7);
    check_fetch(16'd9);
    check_fetch(16'd1);

    sw[0] = 32'hFFFFFFFF;
    sw[1] = 32'h00000002;
    session(2, 1'b1, 0, 1'b0);
    check("cks_vec", ld_checksum, CksEn ? 32'h00000001 : 32'h0);

    for (int s = 0; s < 6; s++) begin
      int n;
      bit ul;
      n  = int'($urandom_range(1, MW));
      ul = (n < MW) ? 1'b1 : 1'($urandom_range(0, 1));
      for (int i = 0; i < MW; i++) sw[i] = $urandom;
      session(n, ul, 3, 1'b1);
      for (int r = 0; r < 8; r++) check_fetch(16'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
